// File: rtl/sphere_column_engine.sv
// Sequential sphere cross-section column renderer: one row per clock, two columns per request,
// results returned through a valid/ready handshake.
module sphere_column_engine #(
   parameter int ROTATIONAL_RES = 256,
   parameter int NUM_COLS       = 64,
   parameter int NUM_ROWS       = 64,
   parameter int RGB_RES        = 9,
   parameter int DEPTH_SHIFT    = 4
) (
   input  logic                                      clk_in,
   input  logic                                      rst_n_in,
   input  logic                                      req_valid,
   output logic                                      req_ready,
   input  logic [$clog2(ROTATIONAL_RES)-1:0]         dtheta,
   input  logic [$clog2(NUM_COLS)-1:0]               col_a,
   input  logic [$clog2(NUM_COLS)-1:0]               col_b,
   input  logic [$clog2(NUM_ROWS)-1:0]               radius,
   input  logic [1:0]                                mode,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]     columns
);

   localparam int AW = $clog2(ROTATIONAL_RES);
   localparam int CW = $clog2(NUM_COLS);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int SW = 2 * CW + 2;
   localparam int C  = RGB_RES / 3;

   localparam logic [CW-1:0] CX        = CW'(NUM_COLS / 2);
   localparam logic [RW-1:0] CY        = RW'(NUM_ROWS / 2);
   localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
   localparam logic [AW-1:0] HALF_TURN = AW'(ROTATIONAL_RES / 2);
   localparam logic [SW-1:0] LEVEL_MAX = SW'(2 ** C - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef enum logic [1:0] {
      MODE_SPLIT     = 2'd0,
      MODE_ANGLE     = 2'd1,
      MODE_DEPTH     = 2'd2,
      MODE_SPLIT_ALT = 2'd3
   } mode_t;

   state_t          state, state_nxt;
   logic [RW-1:0]   row;
   logic [AW-1:0]   dtheta_q;
   logic [CW-1:0]   col_a_q, col_b_q;
   logic [RW-1:0]   radius_q;
   mode_t           mode_q;
   logic            accept, last_row;
   logic [RGB_RES-1:0] pix_a, pix_b;

   // Colour of one pixel; distances are unsigned magnitudes so nothing ever wraps.
   function automatic logic [RGB_RES-1:0] shade(
      input logic [CW-1:0] col,
      input logic [RW-1:0] r,
      input logic          side_b,
      input logic [AW-1:0] dth,
      input logic [RW-1:0] rad,
      input mode_t         md
   );
      logic [CW-1:0]      dx;
      logic [RW-1:0]      dy;
      logic [SW-1:0]      d2, r2, shifted;
      logic [C-1:0]       t, level;
      logic [RGB_RES-1:0] pix;
      dx      = (col >= CX) ? col - CX : CX - col;
      dy      = (r >= CY) ? r - CY : CY - r;
      d2      = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
      r2      = SW'(rad) * SW'(rad);
      shifted = (r2 - d2) >> DEPTH_SHIFT;
      level   = (shifted > LEVEL_MAX) ? {C{1'b1}} : shifted[C-1:0];
      t       = dth[AW-1 -: C];
      case (md)
         MODE_ANGLE: pix = {t, ~t, {C{1'b0}}};
         MODE_DEPTH: pix = {level, level, level};
         default:    pix = ((dth < HALF_TURN) != side_b) ? '1 : '0;
      endcase
      if (d2 > r2) pix = '0;
      return pix;
   endfunction

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise a path that skips it infers a latch.
      state_nxt = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last_row  = (row == LAST_ROW);
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: if (last_row) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pix_a = shade(col_a_q, row, 1'b0, dtheta_q, radius_q, mode_q);
      pix_b = shade(col_b_q, row, 1'b1, dtheta_q, radius_q, mode_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         row      <= '0;
         dtheta_q <= '0;
         col_a_q  <= '0;
         col_b_q  <= '0;
         radius_q <= '0;
         mode_q   <= MODE_SPLIT;
         // NOTE: the column buffer is reset (unlike a RAM) because an aborted scan must never leave stale pixels.
         columns  <= '0;
      end else if (accept) begin
         row      <= '0;
         dtheta_q <= dtheta;
         col_a_q  <= col_a;
         col_b_q  <= col_b;
         radius_q <= radius;
         mode_q   <= mode_t'(mode);
         columns  <= '0;
      end else if (state == SCAN) begin
         columns[0][row] <= pix_a;
         columns[1][row] <= pix_b;
         if (!last_row) row <= row + RW'(1);
      end
   end

endmodule

// File: doc/sphere_column_engine.md
# sphere_column_engine

- Sequential, parametrised successor to the combinational sphere-column generator.
- Per request, it renders two display columns, A and B, of a sphere cross-section for one rotational slice `dtheta`.
- Radius and colour mode are set at run time; the engine scans one row per clock and returns both columns through a valid/ready handshake.
- It sits between the rotation/column scheduler and the LED column driver, which consumes `columns` once per slice.

## Interface

Parameters:
- `ROTATIONAL_RES`, default 256: discrete angles per revolution.
- `NUM_COLS`, default 64: panel columns.
- `NUM_ROWS`, default 64: panel rows.
- `RGB_RES`, default 9: bits per pixel. Must be a multiple of 3. C = RGB_RES/3 bits per channel, packed {R,G,B} with R in the MSBs.
- `DEPTH_SHIFT`, default 4: right shift applied to depth in DEPTH mode.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_in`, in, 1: system clock.
  - `rst_n_in`, in, 1: asynchronous, active-low reset.
- Request side:
  - `req_valid`, in, 1: request present.
  - `req_ready`, out, 1: engine can accept a request.
  - `dtheta`, in, $clog2(ROTATIONAL_RES): slice angle.
  - `col_a`, in, $clog2(NUM_COLS): column A index.
  - `col_b`, in, $clog2(NUM_COLS): column B index.
  - `radius`, in, $clog2(NUM_ROWS): sphere radius in pixels.
  - `mode`, in, 2: 0 SPLIT, 1 ANGLE, 2 DEPTH, 3 treated as SPLIT.
- Output side:
  - `out_valid`, out, 1: `columns` is complete.
  - `out_ready`, in, 1: consumer accepts `columns`.
  - `columns`, out, [1:0][NUM_ROWS-1:0][RGB_RES-1:0]: index 0 is column A, index 1 is column B.

## Operation

- States: IDLE, SCAN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `dtheta`, `col_a`, `col_b`, `radius`, `mode`; clear `columns` to 0; clear row counter; go to SCAN.
- SCAN:
  - Each cycle, evaluate row r = row counter for both columns and write `columns[0][r]` and `columns[1][r]`.
  - On r = NUM_ROWS-1, go to DONE; otherwise increment r.
  - Request inputs are ignored while in SCAN.
- DONE:
  - `out_valid`=1; `columns` is held stable.
  - On `out_valid && out_ready`, go to IDLE.
- Geometry, per column:
  - CX = NUM_COLS/2, CY = NUM_ROWS/2.
  - dx = |col - CX|, dy = |r - CY|; compute as unsigned magnitudes, never wrapped subtraction.
  - Squares and sums use 2*$clog2(NUM_COLS)+2 bits; no overflow is permitted.
  - A pixel is inside when dx²+dy² <= radius². Outside pixels are 0.
- Colour of inside pixels (h = ROTATIONAL_RES/2):
  - SPLIT: column A is all-ones if dtheta < h, else 0. Column B is the inverse: 0 if dtheta < h, else all-ones.
  - ANGLE: T = top C bits of dtheta. Pixel = {T, ~T, C'b0}, identical for both columns.
  - DEPTH: depth = radius² - (dx²+dy²). level = min(depth >> DEPTH_SHIFT, 2^C-1). Pixel = {level, level, level}.
- Any column index is legal; indices far from centre simply produce all-zero columns.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE; row counter and `columns` go to 0.
  - `out_valid`=0, `req_ready`=1 on the first cycle after deassertion.
- Accept edge: the edge where `req_valid && req_ready`, call it E0.
  - Row r is written on edge E(r+1).
  - `out_valid` is high after edge E(NUM_ROWS): latency is NUM_ROWS cycles, 64 at default parameters.
- `req_ready` is low from the edge after E0 until the output handshake completes; there is no overlap of requests.
- Output handshake edge:
  - The next cycle is IDLE with `req_ready`=1.
  - A new request can be accepted on the following edge, so minimum request spacing is NUM_ROWS+2 cycles.
- Backpressure: `out_ready` low holds DONE indefinitely with `columns` bit-stable.
- Reset mid-SCAN or mid-DONE: the request is aborted and nothing is emitted.
- radius=0: only the pixel with dx=dy=0 is inside.

## Test plan

Defaults, radius 20, col_a=32, col_b=40 unless stated.

- SPLIT:
  - dtheta=10 -> `columns[0]` rows 12..52 = 0x1FF, rows 0..11 and 53..63 = 0; `columns[1]` all 0.
  - dtheta=200 -> `columns[0]` all 0; `columns[1]` rows 14..50 = 0x1FF, others 0.
- ANGLE, dtheta=0xA5 -> inside pixels = 0x150 in both columns; outside = 0.
- DEPTH, col_a=32:
  - row 32 -> 0x1FF (saturated).
  - row 13 (dy=19, depth 39) -> 0x092.
  - row 12 (dy=20, depth 0) -> 0.
  - row 11 (outside) -> 0.
- Latency and backpressure:
  - Accept at cycle 0 -> `out_valid` rises after 64 edges.
  - Hold `out_ready`=0 for 10 cycles -> `columns` unchanged and `req_ready`=0 throughout.
  - Release `out_ready` -> `req_ready`=1 in the next cycle.
- Reset and inputs during SCAN:
  - Assert `rst_n_in`=0 at row 20 -> `out_valid`=0, `columns`=0 immediately; IDLE after release.
  - Change `mode` and `dtheta` during SCAN -> output still matches the values latched at acceptance.
- radius=0, col_a=32, col_b=33, SPLIT, dtheta=0 -> `columns[0][32]`=0x1FF and every other pixel of both columns = 0.
